// File: rtl/washer_pkg.sv
// Shared definitions for the washing-machine plant model: default durations,
// width helper, timer indices and the controller state encoding used by benches.
package washer_pkg;

    localparam int LEVEL_MAX_DEF        = 8;
    localparam int DETERGENT_CYCLES_DEF = 3;
    localparam int WASH_CYCLES_DEF      = 16;
    localparam int SPIN_CYCLES_DEF      = 12;

    // Dwell timer slots inside washer_sensor_timer
    localparam int TMR_DET  = 0;
    localparam int TMR_WASH = 1;
    localparam int TMR_SPIN = 2;
    localparam int TMR_NUM  = 3;

    typedef enum logic [2:0] {
        CTRL_CHECK_DOOR    = 3'd0,
        CTRL_FILL_WATER    = 3'd1,
        CTRL_ADD_DETERGENT = 3'd2,
        CTRL_CYCLE         = 3'd3,
        CTRL_DRAIN_WATER   = 3'd4,
        CTRL_SPIN          = 3'd5
    } ctrl_state_t;

    // Ceiling log2, minimum result 1 so a width is never zero.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/washer_dwell_timer.sv
// Counts enabled edges up to TERMINAL and raises a sticky done flag on the last
// one; enable low holds the count, clear zeroes count and done.
module washer_dwell_timer
    import washer_pkg::*;
#(
    parameter int TERMINAL = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic done,
    output logic hit
);

    localparam int CW = clog2(TERMINAL + 1);
    localparam logic [CW-1:0] COUNT_LAST = CW'(TERMINAL - 1);
    localparam logic [CW-1:0] COUNT_TERM = CW'(TERMINAL);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          done_reg;
    logic          done_next;

    // hit marks the edge on which done is about to rise
    assign hit = enable && !clear && (count_reg == COUNT_LAST);

    always_comb begin
        count_next = count_reg;
        done_next  = done_reg;
        if (clear) begin
            count_next = '0;
            done_next  = 1'b0;
        end else if (enable && (count_reg != COUNT_TERM)) begin
            count_next = count_reg + 1'b1;
            if (hit) begin
                done_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            done_reg  <= done_next;
        end
    end

    assign done = done_reg;

endmodule

// File: rtl/washer_sensor_timer.sv
// Plant-side responder: turns controller actuator outputs into tub level,
// full/empty sensors, detergent, wash and spin timeouts and an illegal-actuation flag.
module washer_sensor_timer
    import washer_pkg::*;
#(
    parameter  int LEVEL_MAX        = LEVEL_MAX_DEF,
    parameter  int DETERGENT_CYCLES = DETERGENT_CYCLES_DEF,
    parameter  int WASH_CYCLES      = WASH_CYCLES_DEF,
    parameter  int SPIN_CYCLES      = SPIN_CYCLES_DEF,
    localparam int LW               = clog2(LEVEL_MAX + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          door_lock,
    input  logic          motor_on,
    input  logic          fill_value_on,
    input  logic          drain_value_on,
    input  logic          soap_wash,
    input  logic          water_wash,
    output logic          filled,
    output logic          drained,
    output logic          detergent_added,
    output logic          cycle_timeout,
    output logic          spin_timeout,
    output logic [LW-1:0] water_level,
    output logic          fault
);

    localparam logic [LW-1:0] LEVEL_FULL = LW'(LEVEL_MAX);

    logic [LW-1:0]      level_reg;
    logic [LW-1:0]      level_next;
    logic               detergent_reg;
    logic               detergent_next;
    logic               fault_reg;
    logic               fault_next;

    logic [TMR_NUM-1:0] tmr_enable;
    logic [TMR_NUM-1:0] tmr_clear;
    logic [TMR_NUM-1:0] tmr_done;
    logic [TMR_NUM-1:0] tmr_hit;

    logic               det_qual;
    logic               wash_qual;
    logic               spin_qual;

    // Water level: saturating single-step integrator, overlap of fill and drain holds
    always_comb begin
        level_next = level_reg;
        if (fill_value_on && !drain_value_on && (level_reg != LEVEL_FULL)) begin
            level_next = level_reg + 1'b1;
        end else if (drain_value_on && !fill_value_on && (level_reg != '0)) begin
            level_next = level_reg - 1'b1;
        end
    end

    assign filled  = (level_reg == LEVEL_FULL);
    assign drained = (level_reg == '0);

    assign det_qual  = soap_wash && filled;
    assign wash_qual = motor_on && filled && !drain_value_on;
    assign spin_qual = motor_on && drain_value_on && drained;

    assign tmr_enable[TMR_DET]  = det_qual;
    assign tmr_clear[TMR_DET]   = !det_qual;
    assign tmr_enable[TMR_WASH] = wash_qual;
    assign tmr_clear[TMR_WASH]  = !motor_on;
    assign tmr_enable[TMR_SPIN] = spin_qual;
    assign tmr_clear[TMR_SPIN]  = !motor_on;

    generate
        for (genvar gi = 0; gi < TMR_NUM; gi++) begin : g_timer
            washer_dwell_timer #(
                .TERMINAL((gi == TMR_DET)  ? DETERGENT_CYCLES :
                          (gi == TMR_WASH) ? WASH_CYCLES : SPIN_CYCLES)
            ) u_timer (
                .clk    (clk),
                .reset  (reset),
                .enable (tmr_enable[gi]),
                .clear  (tmr_clear[gi]),
                .done   (tmr_done[gi]),
                .hit    (tmr_hit[gi])
            );
        end
    endgenerate

    // The detergent flag outlives its qualifier; only an empty tub clears it,
    // and an empty tub beats a completion landing on the same edge.
    always_comb begin
        detergent_next = detergent_reg;
        if (level_next == '0) begin
            detergent_next = 1'b0;
        end else if (tmr_hit[TMR_DET]) begin
            detergent_next = 1'b1;
        end
    end

    assign fault_next = fault_reg
                      | (fill_value_on && drain_value_on)
                      | (motor_on && !door_lock);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_reg     <= '0;
            detergent_reg <= 1'b0;
            fault_reg     <= 1'b0;
        end else begin
            level_reg     <= level_next;
            detergent_reg <= detergent_next;
            fault_reg     <= fault_next;
        end
    end

    assign water_level     = level_reg;
    assign detergent_added = detergent_reg;
    assign cycle_timeout   = tmr_done[TMR_WASH];
    assign spin_timeout    = tmr_done[TMR_SPIN];
    assign fault           = fault_reg;

    // Rinse phase and the detergent timer's own done flag carry no plant behaviour
    logic unused_inputs;
    assign unused_inputs = &{1'b0, water_wash, tmr_done[TMR_DET],
                             tmr_hit[TMR_WASH], tmr_hit[TMR_SPIN]};

endmodule

// File: tb/tb_washer_sensor_timer.sv
// Directed bench for washer_sensor_timer: reset, fill/drain, detergent, wash,
// spin, fault and a bench-driven end-to-end wash sequence.
module tb_washer_sensor_timer;
    import washer_pkg::*;

    logic       clk;
    logic       reset;
    logic       door_lock;
    logic       motor_on;
    logic       fill_value_on;
    logic       drain_value_on;
    logic       soap_wash;
    logic       water_wash;
    logic       filled;
    logic       drained;
    logic       detergent_added;
    logic       cycle_timeout;
    logic       spin_timeout;
    logic [3:0] water_level;
    logic       fault;

    int n_cmp;
    int n_bad;
    int n;
    ctrl_state_t phase;

    washer_sensor_timer dut (
        .clk             (clk),
        .reset           (reset),
        .door_lock       (door_lock),
        .motor_on        (motor_on),
        .fill_value_on   (fill_value_on),
        .drain_value_on  (drain_value_on),
        .soap_wash       (soap_wash),
        .water_wash      (water_wash),
        .filled          (filled),
        .drained         (drained),
        .detergent_added (detergent_added),
        .cycle_timeout   (cycle_timeout),
        .spin_timeout    (spin_timeout),
        .water_level     (water_level),
        .fault           (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int edges);
        repeat (edges) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("check %-22s observed %0d expected %0d", tag, obs, exp);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        phase = CTRL_CHECK_DOOR;
        reset = 1'b0;
        door_lock = 1'b0; motor_on = 1'b0; fill_value_on = 1'b0;
        drain_value_on = 1'b0; soap_wash = 1'b0; water_wash = 1'b0;

        // Reset state
        step(2);
        check("rst_level", water_level, 0);
        check("rst_drained", drained, 1);
        check("rst_filled", filled, 0);
        check("rst_detergent", detergent_added, 0);
        check("rst_cycle_to", cycle_timeout, 0);
        check("rst_spin_to", spin_timeout, 0);
        check("rst_fault", fault, 0);
        reset = 1'b1;
        step(1);
        check("idle_level", water_level, 0);

        // Fill from empty: filled after exactly 8 edges, then saturate
        fill_value_on = 1'b1;
        step(7);
        check("fill7_filled", filled, 0);
        check("fill7_level", water_level, 7);
        step(1);
        check("fill8_filled", filled, 1);
        step(2);
        check("fill_sat_level", water_level, 8);
        fill_value_on = 1'b0;

        // Detergent: a 2-edge pulse does not count, 3 consecutive edges do
        soap_wash = 1'b1;
        step(2);
        check("soap_pulse_det", detergent_added, 0);
        soap_wash = 1'b0;
        step(1);
        soap_wash = 1'b1;
        step(2);
        check("soap2_det", detergent_added, 0);
        step(1);
        check("soap3_det", detergent_added, 1);
        soap_wash = 1'b0;
        step(1);
        check("soap_off_det_sticky", detergent_added, 1);

        // Wash timer: timeout on the 16th qualifying edge, falls when motor drops
        door_lock = 1'b1;
        motor_on  = 1'b1;
        step(15);
        check("wash15_cto", cycle_timeout, 0);
        step(1);
        check("wash16_cto", cycle_timeout, 1);
        step(3);
        check("wash_hold_cto", cycle_timeout, 1);
        motor_on = 1'b0;
        step(1);
        check("motor_off_cto", cycle_timeout, 0);

        // Drain on edge 10 freezes the count (fill overlaps so the level holds)
        motor_on = 1'b1;
        step(9);
        drain_value_on = 1'b1;
        fill_value_on  = 1'b1;
        step(1);
        check("freeze_level", water_level, 8);
        drain_value_on = 1'b0;
        fill_value_on  = 1'b0;
        step(6);
        check("freeze16_cto", cycle_timeout, 0);
        step(1);
        check("freeze17_cto", cycle_timeout, 1);
        check("overlap_fault", fault, 1);
        motor_on = 1'b0;
        step(1);

        // Drain with motor on: drained after 8 edges clears detergent, spin 12 later
        drain_value_on = 1'b1;
        motor_on       = 1'b1;
        step(7);
        check("drain7_drained", drained, 0);
        check("drain7_det", detergent_added, 1);
        step(1);
        check("drain8_drained", drained, 1);
        check("drain8_det_clr", detergent_added, 0);
        check("drain_cto_none", cycle_timeout, 0);
        step(11);
        check("spin11_sto", spin_timeout, 0);
        step(1);
        check("spin12_sto", spin_timeout, 1);
        motor_on       = 1'b0;
        drain_value_on = 1'b0;
        step(1);
        check("spin_motor_off_sto", spin_timeout, 0);

        // Fault: reset clears it, fill/drain overlap sets it and it sticks
        reset = 1'b0;
        #1;
        check("fault_rst", fault, 0);
        reset = 1'b1;
        step(1);
        fill_value_on  = 1'b1;
        drain_value_on = 1'b1;
        step(1);
        check("overlap_fault1", fault, 1);
        check("overlap_level_hold", water_level, 0);
        fill_value_on  = 1'b0;
        drain_value_on = 1'b0;
        step(3);
        check("overlap_fault_sticky", fault, 1);

        // Fault: motor running with door unlocked
        reset = 1'b0;
        door_lock = 1'b0;
        step(1);
        reset = 1'b1;
        check("door_pre_fault", fault, 0);
        motor_on = 1'b1;
        step(1);
        check("door_fault", fault, 1);
        motor_on = 1'b0;
        step(2);
        check("door_fault_sticky", fault, 1);

        // Asynchronous reset mid-fill at level 5
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        fill_value_on = 1'b1;
        step(5);
        check("midfill_level5", water_level, 5);
        reset = 1'b0;
        #1;
        check("midfill_rst_level", water_level, 0);
        check("midfill_rst_drained", drained, 1);
        step(1);
        check("midfill_rst_hold", water_level, 0);
        fill_value_on = 1'b0;
        reset = 1'b1;
        step(1);

        // End-to-end: fill, soap, wash, drain, spin with bounded waits
        door_lock = 1'b1;
        phase = CTRL_FILL_WATER;
        fill_value_on = 1'b1;
        n = 0;
        while (!filled && n < 40) begin step(1); n++; end
        check("loop_fill_edges", n, 8);
        fill_value_on = 1'b0;

        phase = CTRL_ADD_DETERGENT;
        soap_wash = 1'b1;
        n = 0;
        while (!detergent_added && n < 40) begin step(1); n++; end
        check("loop_soap_edges", n, 3);
        soap_wash = 1'b0;

        phase = CTRL_CYCLE;
        motor_on = 1'b1;
        n = 0;
        while (!cycle_timeout && n < 60) begin step(1); n++; end
        check("loop_wash_edges", n, 16);
        motor_on = 1'b0;
        step(1);

        phase = CTRL_DRAIN_WATER;
        drain_value_on = 1'b1;
        motor_on = 1'b1;
        n = 0;
        while (!spin_timeout && n < 80) begin step(1); n++; end
        phase = CTRL_SPIN;
        check("loop_drain_spin_edges", n, 20);
        check("loop_done_drained", drained, 1);
        check("loop_fault", fault, 0);
        $display("loop reached phase %s", phase.name());
        motor_on = 1'b0;
        drain_value_on = 1'b0;
        step(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/washer_sensor_timer.md
# washer_sensor_timer

Synthesizable plant-side responder for the automatic washing machine controller. It consumes the controller's actuator outputs (door lock, motor, fill/drain valves, wash-phase flags) and produces the sensor and timer inputs the controller waits on: filled, drained, detergent_added, cycle_timeout and spin_timeout. It closes the loop for self-checking system benches and FPGA demos, replacing hand-timed stimulus.

## Interface
- LEVEL_MAX, 8: water-level count at which the tub is full; fill and drain move 1 per cycle.
- DETERGENT_CYCLES, 3: consecutive qualifying cycles needed to dispense detergent.
- WASH_CYCLES, 16: agitation cycles before cycle_timeout.
- SPIN_CYCLES, 12: spin cycles before spin_timeout.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- door_lock  in  1  controller door lock.
- motor_on  in  1  controller motor enable.
- fill_value_on  in  1  fill valve open.
- drain_value_on  in  1  drain valve open.
- soap_wash  in  1  controller in soap-wash phase.
- water_wash  in  1  controller in rinse phase; informational, no effect on timers.
- filled  out  1  water_level == LEVEL_MAX.
- drained  out  1  water_level == 0.
- detergent_added  out  1  sticky dispense-complete flag.
- cycle_timeout  out  1  agitation time elapsed.
- spin_timeout  out  1  spin time elapsed.
- water_level  out  clog2(LEVEL_MAX+1)  current tub level.
- fault  out  1  sticky illegal-actuation flag.

## Operation
- Reset values: water_level=0, drained=1, filled=0, detergent_added=0, cycle_timeout=0, spin_timeout=0, fault=0, all counters 0.
- Water level (registered, saturating 0..LEVEL_MAX):
  - fill only: +1 per edge, stops at LEVEL_MAX.
  - drain only: -1 per edge, stops at 0.
  - both or neither: hold.
- filled/drained: combinational decode of registered water_level; no added latency.
- Detergent: counter increments on each edge with soap_wash && filled; clears on any edge without it (no partial accumulation). detergent_added sets on the edge the count reaches DETERGENT_CYCLES. It stays set until water_level returns to 0, which clears it on that edge.
- Wash timer:
  - Qualifier: motor_on && filled && !drain_value_on.
  - Counts qualifying edges. cycle_timeout sets on the WASH_CYCLES-th and then holds.
  - A non-qualifying edge with motor_on=1 freezes the count.
  - Any edge with motor_on=0 clears both counter and cycle_timeout.
- Spin timer:
  - Qualifier: motor_on && drain_value_on && drained.
  - Same freeze and clear rules. spin_timeout sets on the SPIN_CYCLES-th qualifying edge.
- fault: set on any edge with (fill_value_on && drain_value_on) or (motor_on && !door_lock). Only reset clears it. fault has no effect on other behaviour.
- Simultaneous events:
  - Drain reaching 0 on the same edge detergent would complete: clear wins.
  - Wash and spin qualifiers are mutually exclusive by construction.

## Timing
- All state updates on rising clk; reset acts asynchronously on assertion and is released synchronously by the system.
- Fill from empty with fill_value_on held continuously: filled rises after exactly LEVEL_MAX edges. Drain from full: drained rises after LEVEL_MAX edges.
- detergent_added: DETERGENT_CYCLES edges after filled && soap_wash first hold at an edge.
- cycle_timeout/spin_timeout: WASH_CYCLES/SPIN_CYCLES qualifying edges after the qualifier begins. They fall one edge after motor_on drops.
- Reset mid-operation returns every output to its reset value within the same cycle, regardless of actuator inputs.

## Structure
- Shared package washer_pkg: default duration constants, level-width helper (clog2), and controller state encoding reused by benches.
- Sub-module washer_dwell_timer: parameter TERMINAL. Inputs: enable, clear. Output: sticky done. Instantiated three times (detergent, wash, spin). The detergent instance uses clear = !qualifier; the wash and spin instances use clear = !motor_on.

## Test plan
- Reset with all actuators 0: water_level=0, drained=1, every other output 0. Assert reset mid-fill at level 5: water_level=0 immediately.
- fill_value_on held from empty: filled=1 exactly 8 edges later. Level saturates at 8 with fill still on. Drain only: drained=1 after 8 edges.
- filled with soap_wash pulsed for 2 edges, then held 3: detergent_added only after the 3 consecutive edges. Draining to 0 clears it.
- Full tub, motor_on held: cycle_timeout=1 at edge 16. Drop motor_on: cycle_timeout=0 next edge. A drain pulse at edge 10 freezes the count, so the timeout arrives at edge 17.
- Drain and motor on from level 8: spin counting starts when drained rises; spin_timeout=1 after 12 further edges.
- Fill and drain both on for 1 edge, and motor_on with door_lock=0: fault=1 and sticky. Level holds during the overlap.
- Full loop with the controller: the sequence fill → soap → wash → drain → spin completes and the controller asserts done.
